fft_out_serializer: RTL

//  Downstream stage of the 16-point FFT core. Captures each parallel result frame
//  (N complex samples, presented for one cycle) into a ping-pong buffer. Streams the

---
 rtl/fft_out_serializer_if.sv | 26 ++
 rtl/fft_out_serializer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fft_out_serializer_if.sv
// Handshake bundle between the FFT core, the output serializer and its downstream consumer.
// The serializer uses the master modport; the driving/consuming side uses slave.
interface fft_out_serializer_if #(
  parameter int N_POINTS = 16,
  parameter int DW       = 12,
  parameter int IW       = $clog2(N_POINTS)
);
  logic                               i_valid;
  logic [N_POINTS-1:0][1:0][DW-1:0]   i_data;
  logic                               i_ready;
  logic                               o_valid;
  logic [1:0][DW-1:0]                 o_data;
  logic [IW-1:0]                      o_index;
  logic                               o_last;
  logic                               o_overflow;

  modport master (
    input  i_valid, i_data, i_ready,
    output o_valid, o_data, o_index, o_last, o_overflow
  );

  modport slave (
    output i_valid, i_data, i_ready,
    input  o_valid, o_data, o_index, o_last, o_overflow
  );
endinterface

// File: rtl/fft_out_serializer.sv
// Ping-pong frame buffer that streams each parallel FFT result out one bin per cycle,
// optionally reordering bit-reversed slots into natural bin order.
//
// state    | meaning
// ST_IDLE  | no sample presented; waiting for bank rd_ptr to fill
// ST_STREAM| o_valid high; presenting bin k of bank rd_ptr
module fft_out_serializer #(
  parameter int N_POINTS = 16,
  parameter int DW       = 12,
  parameter int BIT_REV  = 1
) (
  input  logic               clk,
  input  logic               rst_sync,
  fft_out_serializer_if.master bus
);
  localparam int IW = $clog2(N_POINTS);
  localparam logic [IW-1:0] K_LAST = IW'(N_POINTS - 1);

  typedef logic [1:0][DW-1:0]               sample_t;
  typedef logic [N_POINTS-1:0][1:0][DW-1:0] frame_t;
  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t             state_q, state_d;
  frame_t [1:0]       bank_q, bank_d;
  logic   [1:0]       full_q, full_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;
  sample_t            data_q, data_d;
  logic   [IW-1:0]    idx_q, idx_d;
  logic               last_q, last_d;

  logic               xfer, last_xfer, wr_free, wr_en, wr_other, other_ready;
  logic               ld_en;
  logic   [IW-1:0]    ld_k;
  frame_t             ld_frame;

  function automatic logic [IW-1:0] slot_of(input logic [IW-1:0] k);
    logic [IW-1:0] r;
    r = k;
    if (BIT_REV != 0) begin
      for (int b = 0; b < IW; b++) r[b] = k[IW-1-b];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q  <= ST_IDLE;
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
    bank_q <= bank_d;
  end

  // A bank emptied by this cycle's final beat may be refilled in the same cycle.
  always_comb begin
    xfer        = (state_q == ST_STREAM) && bus.i_ready;
    last_xfer   = xfer && (idx_q == K_LAST);
    wr_free     = !full_q[wr_ptr_q] || (last_xfer && (rd_ptr_q == wr_ptr_q));
    wr_en       = bus.i_valid && wr_free;
    wr_other    = wr_en && (wr_ptr_q != rd_ptr_q);
    other_ready = full_q[~rd_ptr_q] || wr_other;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (full_q[rd_ptr_q]) state_d = ST_STREAM;
      ST_STREAM: if (last_xfer && !other_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bank_d   = bank_q;
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    data_d   = data_q;
    idx_d    = idx_q;
    last_d   = last_q;
    ld_en    = 1'b0;
    ld_k     = '0;
    ld_frame = bank_q[rd_ptr_q];

    if (last_xfer) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
    if (wr_en) begin
      bank_d[wr_ptr_q] = bus.i_data;
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (bus.i_valid && !wr_free) ovf_d = 1'b1;

    // Handing straight to a frame landing this cycle must bypass the bank write.
    if (state_q == ST_IDLE && full_q[rd_ptr_q]) begin
      ld_en = 1'b1;
    end else if (xfer && !last_xfer) begin
      ld_en = 1'b1;
      ld_k  = idx_q + 1'b1;
    end else if (last_xfer && other_ready) begin
      ld_en    = 1'b1;
      ld_frame = wr_other ? bus.i_data : bank_q[~rd_ptr_q];
    end

    if (ld_en) begin
      data_d = ld_frame[slot_of(ld_k)];
      idx_d  = ld_k;
      last_d = (ld_k == K_LAST);
    end
  end

  assign bus.o_valid    = (state_q == ST_STREAM);
  assign bus.o_data     = data_q;
  assign bus.o_index    = idx_q;
  assign bus.o_last     = last_q;
  assign bus.o_overflow = ovf_q;
endmodule
